vga_sync_gen: RTL and testbench

//  - Produces the VGA raster for the pixel renderers: pixel strobe, pixel coordinates x/y, video_on, hsync and vsync.
//  - Sits between the 100 MHz board clock and the graphics and text blocks, which sample x/y/video_on.
//  - Sync pins go straight to the connector.
//  - Default timing: 640x480 @ 60 Hz, 25 MHz pixel rate derived by clock-enable, no second clock domain.

---
 rtl/vga_sync_gen.sv | 85 ++++++++
 tb/tb_vga_sync_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster generator: pixel strobe by clock-enable, x/y counters, registered syncs and ticks.
// Sync levels are registered from the next count values so they change on the same edge as x/y.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div;
    logic             adv;
    logic             x_last;
    logic             y_last;
    logic [9:0]       x_next;
    logic [9:0]       y_next;

    always_comb begin
        adv    = (div == DIV_LAST);
        x_last = (x == X_LAST);
        y_last = (y == Y_LAST);
        x_next = x;
        y_next = y;
        if (adv) begin
            x_next = x_last ? 10'd0 : x + 10'd1;
            if (x_last) begin
                y_next = y_last ? 10'd0 : y + 10'd1;
            end
        end
    end

    assign video_on = (x < 10'(H_DISPLAY)) && (y < 10'(V_DISPLAY));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div        <= '0;
            p_tick     <= 1'b0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
            x          <= 10'd0;
            y          <= 10'd0;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
        end else begin
            div        <= adv ? '0 : div + DIV_W'(1);
            p_tick     <= adv;
            line_tick  <= adv && x_last;
            frame_tick <= adv && x_last && y_last;
            x          <= x_next;
            y          <= y_next;
            // Decode from the next counts so the sync edge lines up with the x/y it belongs to.
            hsync      <= ((x_next >= HS_START) && (x_next <= HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync      <= ((y_next >= VS_START) && (y_next <= VS_END)) ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default timing, a shrunken raster for frame/reset behaviour,
// and a CLK_DIV=1 active-high variant.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Instance A: default 640x480 timing
    logic       reset_a;
    logic       p_tick_a, video_on_a, hsync_a, vsync_a, line_tick_a, frame_tick_a;
    logic [9:0] x_a, y_a;
    vga_sync_gen dut_a (
        .clk(clk), .reset(reset_a), .p_tick(p_tick_a), .x(x_a), .y(y_a),
        .video_on(video_on_a), .hsync(hsync_a), .vsync(vsync_a),
        .line_tick(line_tick_a), .frame_tick(frame_tick_a)
    );

    // Instance B: 16x10 raster, CLK_DIV=2; hsync x=12..14, vsync y=7..8
    logic       reset_b;
    logic       p_tick_b, video_on_b, hsync_b, vsync_b, line_tick_b, frame_tick_b;
    logic [9:0] x_b, y_b;
    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset_b), .p_tick(p_tick_b), .x(x_b), .y(y_b),
        .video_on(video_on_b), .hsync(hsync_b), .vsync(vsync_b),
        .line_tick(line_tick_b), .frame_tick(frame_tick_b)
    );

    // Instance C: default raster, one pixel per clk, active-high syncs
    logic       reset_c;
    logic       p_tick_c, video_on_c, hsync_c, vsync_c, line_tick_c, frame_tick_c;
    logic [9:0] x_c, y_c;
    vga_sync_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) dut_c (
        .clk(clk), .reset(reset_c), .p_tick(p_tick_c), .x(x_c), .y(y_c),
        .video_on(video_on_c), .hsync(hsync_c), .vsync(vsync_c),
        .line_tick(line_tick_c), .frame_tick(frame_tick_c)
    );

    initial begin
        int n_tick, n_hs, n_vs, n_vid, n_line, n_frame, bad, hs_min, hs_max, x_max, y_max;
        logic [9:0] prev_x;

        reset_a = 1'b1;
        reset_b = 1'b1;
        reset_c = 1'b1;
        repeat (3) @(negedge clk);

        // ---- A: reset values
        check("a_rst_x", x_a, 0);
        check("a_rst_y", y_a, 0);
        check("a_rst_ptick", p_tick_a, 0);
        check("a_rst_hsync", hsync_a, 1);
        check("a_rst_vsync", vsync_a, 1);
        check("a_rst_video", video_on_a, 1);
        check("a_rst_ticks", {line_tick_a, frame_tick_a}, 0);

        // ---- A: p_tick at clk 4, 8, 12 after release
        reset_a = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("a_ptick_c%0d", c), p_tick_a, (c % 4 == 0) ? 1 : 0);
            if (c == 4) check("a_x_first", x_a, 1);
        end
        check("a_x_c12", x_a, 3);
        check("a_syncs_c12", {hsync_a, vsync_a}, 2'b11);

        // ---- A: one full line of 800 p_ticks
        n_tick = 0; n_hs = 0; n_vid = 0; n_line = 0; bad = 0;
        hs_min = 1023; hs_max = 0;
        prev_x = x_a;
        for (int c = 0; c < 3200; c++) begin
            @(negedge clk);
            if (x_a != prev_x && !p_tick_a) bad++;
            if (p_tick_a) begin
                n_tick++;
                if (!hsync_a) begin
                    n_hs++;
                    if (int'(x_a) < hs_min) hs_min = int'(x_a);
                    if (int'(x_a) > hs_max) hs_max = int'(x_a);
                end
                if (!video_on_a) n_vid++;
                if (video_on_a != (x_a < 640)) bad++;
            end
            if (line_tick_a) begin
                n_line++;
                check("a_line_tick_x", x_a, 0);
                check("a_line_tick_y", y_a, 1);
                check("a_line_tick_prev", prev_x, 799);
                check("a_line_tick_ptick", p_tick_a, 1);
            end
            prev_x = x_a;
        end
        check("a_line_pticks", n_tick, 800);
        check("a_hsync_width", n_hs, 96);
        check("a_hsync_first", hs_min, 656);
        check("a_hsync_last", hs_max, 751);
        check("a_video_off", n_vid, 160);
        check("a_line_ticks", n_line, 1);
        check("a_line_bad", bad, 0);
        check("a_line_end_x", x_a, 3);
        check("a_line_end_y", y_a, 1);
        check("a_vsync_idle", vsync_a, 1);

        // ---- B: one full frame (160 pixels * 2 clk)
        reset_b = 1'b0;
        n_tick = 0; n_hs = 0; n_vs = 0; n_line = 0; n_frame = 0; bad = 0;
        x_max = 0; y_max = 0;
        for (int c = 1; c <= 320; c++) begin
            @(negedge clk);
            if (p_tick_b) begin
                n_tick++;
                if (!hsync_b) n_hs++;
                if (!vsync_b) n_vs++;
                if (!hsync_b != (x_b >= 12 && x_b <= 14)) bad++;
                if (!vsync_b != (y_b >= 7 && y_b <= 8)) bad++;
                if (video_on_b != (x_b < 10 && y_b < 6)) bad++;
                if (int'(x_b) > x_max) x_max = int'(x_b);
                if (int'(y_b) > y_max) y_max = int'(y_b);
            end
            if (line_tick_b) n_line++;
            if (frame_tick_b) begin
                n_frame++;
                check("b_frame_cycle", c, 320);
                check("b_frame_xy", {x_b, y_b}, 0);
            end
        end
        check("b_pticks", n_tick, 160);
        check("b_hsync_ticks", n_hs, 30);
        check("b_vsync_ticks", n_vs, 32);
        check("b_line_ticks", n_line, 10);
        check("b_frame_ticks", n_frame, 1);
        check("b_decode_bad", bad, 0);
        check("b_x_max", x_max, 15);
        check("b_y_max", y_max, 9);

        // ---- B: advance into both sync pulses, then reset mid-frame
        repeat (250) @(negedge clk);
        check("b_mid_x", x_b, 13);
        check("b_mid_y", y_b, 7);
        check("b_mid_syncs", {hsync_b, vsync_b}, 2'b00);
        #1 reset_b = 1'b1;
        #1;
        check("b_arst_xy", {x_b, y_b}, 0);
        check("b_arst_syncs", {hsync_b, vsync_b}, 2'b11);
        check("b_arst_ticks", {p_tick_b, line_tick_b, frame_tick_b}, 0);
        @(negedge clk);
        reset_b = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("b_restart_ptick_c%0d", c), p_tick_b, (c % 2 == 0) ? 1 : 0);
        end
        check("b_restart_x", x_b, 2);
        check("b_restart_syncs", {hsync_b, vsync_b}, 2'b11);

        // ---- C: CLK_DIV=1, active-high syncs
        check("c_rst_syncs", {hsync_c, vsync_c}, 2'b00);
        check("c_rst_ptick", p_tick_c, 0);
        reset_c = 1'b0;
        n_tick = 0; n_hs = 0; n_vs = 0; n_line = 0; bad = 0;
        for (int c = 1; c <= 800; c++) begin
            @(negedge clk);
            if (p_tick_c) n_tick++;
            if (hsync_c) n_hs++;
            if (vsync_c) n_vs++;
            if (hsync_c != (x_c >= 656 && x_c <= 751)) bad++;
            if (int'(x_c) != c % 800) bad++;
            if (line_tick_c) begin
                n_line++;
                check("c_line_cycle", c, 800);
            end
        end
        check("c_pticks", n_tick, 800);
        check("c_hsync_high", n_hs, 96);
        check("c_vsync_high", n_vs, 0);
        check("c_line_ticks", n_line, 1);
        check("c_bad", bad, 0);
        check("c_end_y", y_c, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
